// File: rtl/bram_frame_sequencer.sv
// bram_frame_sequencer
//   Streams the sample BRAM into the FFT input as framed samples. An accepted
//   start issues max(num_frames,1) x 2^ADDR_W sequential reads (addresses
//   0..2^ADDR_W-1, wrapping once per frame). The BRAM's 1-cycle read latency
//   is absorbed by a 2-entry skid FIFO, so FFT backpressure never drops data.
//
// Ports
//   clk_i         rising-edge clock
//   rst_ni        asynchronous reset, active low
//   start_i       1-cycle start pulse, honoured only in IDLE or DONE
//   num_frames_i  frames to stream, sampled on accepted start (0 -> 1)
//   abort_i       stop issuing, flush buffered data, return to IDLE
//   bram_en_o     BRAM ena (read request this cycle)
//   bram_addr_o   BRAM addra
//   bram_dout_i   BRAM douta, valid one cycle after bram_en_o
//   m_data_o      sample to FFT ({re,im})
//   m_valid_o     m_data_o valid; transfer on m_valid_o & m_ready_i
//   m_ready_i     FFT accepts sample
//   m_sop_o       head sample is address 0 of a frame
//   m_eop_o       head sample is the last address of a frame
//   busy_o        RUN or DRAIN
//   done_o        pulse on the transfer of the last sample of the last frame
//   frame_cnt_o   frames fully transferred since the accepted start
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | issuing BRAM reads
// DRAIN | all reads issued, emptying in-flight read and FIFO
// DONE  | stream complete, waiting for a new start

module bram_frame_sequencer #(
  parameter int FLOAT_LEN = 32,
  parameter int ADDR_W    = 13,
  parameter int FRAME_CW  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [FRAME_CW-1:0]    num_frames_i,
  input  logic                   abort_i,
  output logic                   bram_en_o,
  output logic [ADDR_W-1:0]      bram_addr_o,
  input  logic [2*FLOAT_LEN-1:0] bram_dout_i,
  output logic [2*FLOAT_LEN-1:0] m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_sop_o,
  output logic                   m_eop_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [FRAME_CW-1:0]    frame_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [FRAME_CW-1:0] frames_left_q, frames_left_d;
  logic [FRAME_CW-1:0] frame_cnt_q, frame_cnt_d;

  logic                inflight_q;
  logic                infl_sop_q;
  logic                infl_eop_q;

  logic [2*FLOAT_LEN-1:0] fifo_data_q [2];
  logic                   fifo_sop_q  [2];
  logic                   fifo_eop_q  [2];
  logic [1:0]             fifo_cnt_q;
  logic                   rd_ptr_q;
  logic                   wr_ptr_q;

  logic       pop;
  logic       issue;
  logic       start_ok;
  logic       last_pop;
  logic [2:0] occ;

  assign pop      = (fifo_cnt_q != 2'd0) & m_ready_i;
  assign occ      = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  // A pop this cycle frees a slot, so the limit rises by one when popping.
  assign issue    = (state_q == S_RUN) & ~abort_i & (occ < (pop ? 3'd3 : 3'd2));
  assign start_ok = start_i & ~abort_i & ((state_q == S_IDLE) | (state_q == S_DONE));
  // In DRAIN nothing new is issued, so the only buffered sample leaving is the last one.
  assign last_pop = (state_q == S_DRAIN) & pop & (fifo_cnt_q == 2'd1) & ~inflight_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    frames_left_d = frames_left_q;
    frame_cnt_d   = frame_cnt_q;

    if (pop && fifo_eop_q[rd_ptr_q] && !(&frame_cnt_q)) begin
      frame_cnt_d = frame_cnt_q + FRAME_CW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d       = S_RUN;
          addr_d        = '0;
          frames_left_d = (num_frames_i == '0) ? FRAME_CW'(1) : num_frames_i;
          frame_cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          if (&addr_q) begin
            frames_left_d = frames_left_q - FRAME_CW'(1);
            if (frames_left_q == FRAME_CW'(1)) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      frames_left_q <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      frames_left_q <= frames_left_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Read pipeline and skid FIFO. The tags travel with the read so the FIFO
  // head always knows its own frame position.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_sop_q[i]  <= 1'b0;
        fifo_eop_q[i]  <= 1'b0;
      end
    end else if (abort_i) begin
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      inflight_q <= issue;
      infl_sop_q <= (addr_q == '0);
      infl_eop_q <= &addr_q;
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= bram_dout_i;
        fifo_sop_q[wr_ptr_q]  <= infl_sop_q;
        fifo_eop_q[wr_ptr_q]  <= infl_eop_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign bram_en_o   = issue;
  assign bram_addr_o = addr_q;
  assign m_valid_o   = (fifo_cnt_q != 2'd0);
  assign m_data_o    = fifo_data_q[rd_ptr_q];
  assign m_sop_o     = m_valid_o & fifo_sop_q[rd_ptr_q];
  assign m_eop_o     = m_valid_o & fifo_eop_q[rd_ptr_q];
  assign busy_o      = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done_o      = last_pop & ~abort_i;
  assign frame_cnt_o = frame_cnt_q;

endmodule
